// File: rtl/tb_mem_pkg.sv
// tb_mem_pkg: shared FSM encoding, latency counter width and byte-lane merge for the wait-state RAM
package tb_mem_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;
  localparam int LAT_W = 4;
  function automatic logic [7:0] merge_byte(input logic [7:0] old_b, input logic [7:0] new_b, input logic en);
    return en ? new_b : old_b;
  endfunction
endpackage

// File: rtl/wait_counter.sv
// wait_counter: loadable down-counter; done flags the last wait cycle (count == 1)
module wait_counter import tb_mem_pkg::*; (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [LAT_W-1:0] load_val,
  input  logic             dec,
  output logic             done
);
  logic [LAT_W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load ? load_val : (dec && cnt_q != '0) ? cnt_q - LAT_W'(1) : cnt_q;
  always_ff @(posedge clk or posedge rst_n)
    if (rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign done = cnt_q == LAT_W'(1);
endmodule

// File: rtl/wait_state_ram.sv
// wait_state_ram: word RAM with byte enables, valid/ready request and LATENCY wait states before a one-cycle response.
// Define WAIT_STATE_RAM_TOHOST_EN to map a sticky halt/tohost register at TOHOST_ADDR.
module wait_state_ram import tb_mem_pkg::*; #(
  parameter int                DATA_W      = 32,
  parameter int                ADDR_W      = 32,
  parameter int                DEPTH       = 256,
  parameter int                LATENCY     = 1,
  parameter logic [ADDR_W-1:0] TOHOST_ADDR = ADDR_W'('hFFF0)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_we,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                halted,
  output logic [DATA_W-1:0]   tohost
);
  localparam int BYTES = DATA_W / 8;
  localparam int OFF = $clog2(BYTES);
  localparam int IDX_W = $clog2(DEPTH);
`ifdef WAIT_STATE_RAM_TOHOST_EN
  localparam bit HOST_EN = 1'b1;
`else
  localparam bit HOST_EN = 1'b0;
`endif
  state_t state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d, tohost_q, tohost_d, new_word;
  logic [BYTES-1:0] we_q, we_d;
  logic err_q, err_d, halted_q, halted_d;
  logic accept, done, to_resp, bad, host, host_wr, mem_we;
  logic [IDX_W-1:0] idx;
  logic [DATA_W-1:0] mem [DEPTH];
  wait_counter u_wait_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept),
    .load_val (LAT_W'(LATENCY)),
    .dec      (state_q == WAIT),
    .done     (done)
  );
  assign accept = state_q == IDLE && req_valid;
  always_comb begin
    state_d = state_q;
    if (accept) state_d = LATENCY == 0 ? RESP : WAIT;
    else if (state_q == WAIT && done) state_d = RESP;
    else if (state_q == RESP) state_d = IDLE;
  end
  // The *_d request fields select the live inputs on accept, so LATENCY==0 resolves in the same edge
  always_comb begin
    addr_d = accept ? req_addr : addr_q;
    wdata_d = accept ? req_wdata : wdata_q;
    we_d = accept ? req_we : we_q;
    to_resp = state_d == RESP;
    bad = (addr_d & ADDR_W'(BYTES - 1)) != '0 || addr_d >= ADDR_W'(DEPTH * BYTES);
    host = HOST_EN && addr_d == TOHOST_ADDR;
    host_wr = to_resp && host && |we_d;
    mem_we = to_resp && !bad && !host && |we_d;
    idx = addr_d[IDX_W+OFF-1:OFF];
    err_d = to_resp ? bad && !host : err_q;
    rdata_d = !to_resp ? rdata_q : host ? (|we_d ? wdata_d : tohost_q) : bad ? '0 : new_word;
    halted_d = halted_q || host_wr;
    tohost_d = host_wr ? wdata_d : tohost_q;
  end
  for (genvar i = 0; i < BYTES; i++) begin : g_lane
    assign new_word[8*i +: 8] = merge_byte(mem[idx][8*i +: 8], wdata_d[8*i +: 8], we_d[i]);
  end
  // The array shares the reset block so an aborted write can never commit while reset is held
  always_ff @(posedge clk or posedge rst_n)
    if (rst_n) begin
      state_q <= IDLE;
      addr_q <= '0;
      wdata_q <= '0;
      we_q <= '0;
      rdata_q <= '0;
      err_q <= 1'b0;
      halted_q <= 1'b0;
      tohost_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      we_q <= we_d;
      rdata_q <= rdata_d;
      err_q <= err_d;
      halted_q <= halted_d;
      tohost_q <= tohost_d;
      if (mem_we) mem[idx] <= new_word;
    end
  assign req_ready = state_q == IDLE;
  assign rsp_valid = state_q == RESP;
  assign rsp_rdata = rdata_q;
  assign rsp_err = err_q;
  assign halted = HOST_EN && halted_q;
  assign tohost = HOST_EN ? tohost_q : '0;
endmodule

// File: tb/tb_wait_state_ram.sv
// tb_wait_state_ram: directed and random transactions on three wait_state_ram instances (LATENCY 1, 0, 7) checked against a word/byte reference model
module tb_wait_state_ram;
  localparam int N = 3;
  localparam int LATS [N] = '{1, 0, 7};
`ifdef WAIT_STATE_RAM_TOHOST_EN
  localparam bit HOST_EN = 1'b1;
`else
  localparam bit HOST_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic req_valid [N];
  logic req_ready [N];
  logic [31:0] req_addr [N];
  logic [31:0] req_wdata [N];
  logic [3:0] req_we [N];
  logic rsp_valid [N];
  logic [31:0] rsp_rdata [N];
  logic rsp_err [N];
  logic halted [N];
  logic [31:0] tohost [N];
  int tests = 0;
  int fails = 0;
  logic [31:0] m_mem [N][256];
  bit m_known [N][256];
  logic [31:0] m_tohost [N];
  bit m_halted [N];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    wait_state_ram #(.LATENCY(LATS[g])) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid[g]),
      .req_ready (req_ready[g]),
      .req_addr  (req_addr[g]),
      .req_wdata (req_wdata[g]),
      .req_we    (req_we[g]),
      .rsp_valid (rsp_valid[g]),
      .rsp_rdata (rsp_rdata[g]),
      .rsp_err   (rsp_err[g]),
      .halted    (halted[g]),
      .tohost    (tohost[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] lane_mask(input logic [3:0] we);
    return {{8{we[3]}}, {8{we[2]}}, {8{we[1]}}, {8{we[0]}}};
  endfunction

  task automatic txn(input int d, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] we);
    logic [31:0] exp_rd, rd, m;
    logic er;
    bit bad, host, chk_rd, exp_er;
    int cyc, low, pulses, w, wi;
    bad = (a % 4 != 0) || (a >= 32'd1024);
    host = HOST_EN && a == 32'hFFF0;
    exp_er = bad && !host;
    wi = int'(a[9:2]);
    m = lane_mask(we);
    chk_rd = 1'b0;
    exp_rd = '0;
    if (host) begin
      if (we != 0) begin
        m_tohost[d] = wd;
        m_halted[d] = 1'b1;
      end else begin
        exp_rd = m_tohost[d];
        chk_rd = 1'b1;
      end
    end else if (bad) chk_rd = 1'b1;
    else if (we != 0) begin
      m_mem[d][wi] = (m_mem[d][wi] & ~m) | (wd & m);
      m_known[d][wi] = m_known[d][wi] || we == 4'hF;
    end else if (m_known[d][wi]) begin
      exp_rd = m_mem[d][wi];
      chk_rd = 1'b1;
    end
    @(negedge clk);
    w = 0;
    while (!req_ready[d] && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk($sformatf("d%0d ready_before_req", d), 32'(req_ready[d]), 32'd1);
    req_valid[d] = 1'b1;
    req_addr[d] = a;
    req_wdata[d] = wd;
    req_we[d] = we;
    @(posedge clk);
    #1;
    req_valid[d] = 1'b0;
    cyc = 0;
    low = 0;
    pulses = 0;
    rd = '0;
    er = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (rsp_valid[d]) begin
        if (pulses == 0) begin
          cyc = k + 1;
          rd = rsp_rdata[d];
          er = rsp_err[d];
        end
        pulses++;
      end
      if (req_ready[d]) break;
      low++;
      @(posedge clk);
      #1;
    end
    chk($sformatf("d%0d a=%0h rsp_latency", d, a), 32'(cyc), 32'(LATS[d] + 1));
    chk($sformatf("d%0d a=%0h ready_low", d, a), 32'(low), 32'(LATS[d] + 1));
    chk($sformatf("d%0d a=%0h rsp_pulses", d, a), 32'(pulses), 32'd1);
    chk($sformatf("d%0d a=%0h err", d, a), 32'(er), 32'(exp_er));
    chk($sformatf("d%0d a=%0h err_hold", d, a), 32'(rsp_err[d]), 32'(exp_er));
    if (chk_rd) begin
      chk($sformatf("d%0d a=%0h rdata", d, a), rd, exp_rd);
      chk($sformatf("d%0d a=%0h rdata_hold", d, a), rsp_rdata[d], exp_rd);
    end
    chk($sformatf("d%0d halted", d), 32'(halted[d]), 32'(m_halted[d]));
    chk($sformatf("d%0d tohost", d), tohost[d], m_tohost[d]);
  endtask

  task automatic abort_write(input int d, input logic [31:0] a, input logic [31:0] wd);
    int pulses;
    @(negedge clk);
    req_valid[d] = 1'b1;
    req_addr[d] = a;
    req_wdata[d] = wd;
    req_we[d] = 4'hF;
    @(posedge clk);
    #1;
    req_valid[d] = 1'b0;
    @(posedge clk);
    #1;
    chk("abort in_wait_ready", 32'(req_ready[d]), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("abort ready_in_reset", 32'(req_ready[d]), 32'd1);
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      if (rsp_valid[d]) pulses++;
      if (k == 2) rst_n = 1'b0;
      @(posedge clk);
      #1;
    end
    chk("abort rsp_pulses", 32'(pulses), 32'd0);
    chk("abort ready_after", 32'(req_ready[d]), 32'd1);
    for (int i = 0; i < N; i++) begin
      m_tohost[i] = '0;
      m_halted[i] = 1'b0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, wd;
    logic [3:0] we;
    int r, d;
    for (int i = 0; i < N; i++) begin
      req_valid[i] = 1'b0;
      req_addr[i] = '0;
      req_wdata[i] = '0;
      req_we[i] = '0;
      m_tohost[i] = '0;
      m_halted[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      chk($sformatf("d%0d reset ready", i), 32'(req_ready[i]), 32'd1);
      chk($sformatf("d%0d reset rsp_valid", i), 32'(rsp_valid[i]), 32'd0);
      chk($sformatf("d%0d reset rdata", i), rsp_rdata[i], 32'd0);
      chk($sformatf("d%0d reset err", i), 32'(rsp_err[i]), 32'd0);
      chk($sformatf("d%0d reset halted", i), 32'(halted[i]), 32'd0);
      chk($sformatf("d%0d reset tohost", i), tohost[i], 32'd0);
    end
    txn(0, 32'h4, 32'hDEADBEEF, 4'hF);
    txn(0, 32'h4, 32'h0, 4'h0);
    chk("t1 read_const", rsp_rdata[0], 32'hDEADBEEF);
    txn(0, 32'h4, 32'h000000AA, 4'b0001);
    txn(0, 32'h4, 32'h0, 4'h0);
    chk("t2 lane_const", rsp_rdata[0], 32'hDEADBEAA);
    txn(0, 32'h5, 32'h0, 4'h0);
    chk("t3 misaligned_err", 32'(rsp_err[0]), 32'd1);
    txn(0, 32'h0, 32'hCAFEF00D, 4'hF);
    txn(0, 32'h400, 32'h12345678, 4'hF);
    txn(0, 32'h0, 32'h0, 4'h0);
    chk("t3 alias_unchanged", rsp_rdata[0], 32'hCAFEF00D);
    for (int i = 1; i < N; i++) begin
      txn(i, 32'h10, 32'hA5A5_0000 + 32'(i), 4'hF);
      txn(i, 32'h10, 32'h0, 4'h0);
      txn(i, 32'h3FC, 32'h0BAD_F00D, 4'hF);
      txn(i, 32'h3FC, 32'h0, 4'h0);
    end
    txn(2, 32'h8, 32'h11223344, 4'hF);
    abort_write(2, 32'h8, 32'h55667788);
    txn(2, 32'h8, 32'h0, 4'h0);
    chk("t5 old_value", rsp_rdata[2], 32'h11223344);
    txn(0, 32'hFFF0, 32'h1, 4'hF);
    txn(0, 32'hFFF0, 32'h2, 4'hF);
    txn(0, 32'hFFF0, 32'h0, 4'h0);
    chk("t6 halted_const", 32'(halted[0]), HOST_EN ? 32'd1 : 32'd0);
    chk("t6 tohost_const", tohost[0], HOST_EN ? 32'd2 : 32'd0);
    for (int n = 0; n < 150; n++) begin
      d = int'($urandom_range(0, N - 1));
      r = int'($urandom_range(0, 9));
      a = 32'($urandom_range(0, 15)) << 2;
      if (r == 0) a = a + 32'($urandom_range(1, 3));
      else if (r == 1) a = a + 32'h400;
      else if (r == 2) a = 32'hFFF0;
      wd = $urandom;
      r = int'($urandom_range(0, 9));
      we = r < 4 ? 4'h0 : r < 7 ? 4'hF : 4'($urandom_range(1, 15));
      txn(d, a, wd, we);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
